// File: rtl/probe_pkg.sv
// Shared definitions for the probe averager: FSM state encoding and default sizing.
package probe_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEF_MAX_SAMPLES   = 16;
    localparam int DEF_SETTLE_CYCLES = 2;
    localparam int TIMER_W           = 16;

endpackage

// File: rtl/probe_stats.sv
// Running sum / min / max / count of captured probe voltages.
// Outputs show the statistics as they stand at the end of the current cycle, including a capture made on it.
module probe_stats
    import probe_pkg::*;
#(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear_i,
    input  logic          capture_i,
    input  real           voltage_i,
    output real           sum_o,
    output real           min_o,
    output real           max_o,
    output logic [CW-1:0] count_o
);

    real           sum_q, min_q, max_q;
    logic [CW-1:0] count_q;
    real           sum_d, min_d, max_d;
    logic [CW-1:0] count_d;

    always_comb begin
        sum_d   = sum_q;
        min_d   = min_q;
        max_d   = max_q;
        count_d = count_q;
        if (clear_i) begin
            sum_d   = 0.0;
            min_d   = 0.0;
            max_d   = 0.0;
            count_d = '0;
        end else if (capture_i) begin
            sum_d   = sum_q + voltage_i;
            count_d = count_q + 1'b1;
            // The first sample seeds both extremes instead of comparing against the cleared zeros.
            if (count_q == '0) begin
                min_d = voltage_i;
                max_d = voltage_i;
            end else begin
                min_d = (voltage_i < min_q) ? voltage_i : min_q;
                max_d = (voltage_i > max_q) ? voltage_i : max_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q   <= 0.0;
            min_q   <= 0.0;
            max_q   <= 0.0;
            count_q <= '0;
        end else begin
            sum_q   <= sum_d;
            min_q   <= min_d;
            max_q   <= max_d;
            count_q <= count_d;
        end
    end

    assign sum_o   = sum_d;
    assign min_o   = min_d;
    assign max_o   = max_d;
    assign count_o = count_d;

endmodule

// File: rtl/probe_averager.sv
// Sequences probe toggles, captures the settled voltage after each one, and reports avg/min/max.
// start is sampled only in IDLE; done is a one-cycle pulse; abort cancels SETTLE/WAIT without a done pulse.
module probe_averager
    import probe_pkg::*;
#(
    parameter  int MAX_SAMPLES   = DEF_MAX_SAMPLES,
    parameter  int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    localparam int CW            = $clog2(MAX_SAMPLES + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] num_samples,
    input  logic [15:0]   interval,
    input  real           voltage,
    output logic          probe_toggle,
    output logic          busy,
    output logic          done,
    output real           v_avg,
    output real           v_min,
    output real           v_max,
    output logic [CW-1:0] sample_count,
    output logic [1:0]    state_o
);

    localparam logic [TIMER_W-1:0] SETTLE_RELOAD = TIMER_W'(SETTLE_CYCLES - 1);

    state_t               state_q;
    logic [CW-1:0]        target_q;
    logic [TIMER_W-1:0]   interval_q;
    logic [TIMER_W-1:0]   settle_cnt_q;
    logic [TIMER_W-1:0]   wait_cnt_q;

    logic                 settle_end;
    logic                 cap_en;
    logic                 last_cap;
    logic                 stats_clear;
    logic [CW-1:0]        clamped_n;
    real                  st_sum, st_min, st_max;
    logic [CW-1:0]        st_count;

    assign clamped_n   = (num_samples > CW'(MAX_SAMPLES)) ? CW'(MAX_SAMPLES) : num_samples;
    assign settle_end  = (state_q == SETTLE) && (settle_cnt_q == '0);
    // Abort wins over a capture landing on the same edge.
    assign cap_en      = settle_end && !abort;
    assign last_cap    = cap_en && (st_count == target_q);
    assign stats_clear = (state_q == IDLE) && start && (num_samples != '0);

    probe_stats #(
        .CW(CW)
    ) u_stats (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (stats_clear),
        .capture_i (cap_en),
        .voltage_i (voltage),
        .sum_o     (st_sum),
        .min_o     (st_min),
        .max_o     (st_max),
        .count_o   (st_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            target_q     <= '0;
            interval_q   <= '0;
            settle_cnt_q <= '0;
            wait_cnt_q   <= '0;
            probe_toggle <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            v_avg        <= 0.0;
            v_min        <= 0.0;
            v_max        <= 0.0;
            sample_count <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (num_samples == '0) begin
                            state_q      <= DONE;
                            done         <= 1'b1;
                            v_avg        <= 0.0;
                            v_min        <= 0.0;
                            v_max        <= 0.0;
                            sample_count <= '0;
                        end else begin
                            state_q      <= SETTLE;
                            target_q     <= clamped_n;
                            interval_q   <= interval;
                            settle_cnt_q <= SETTLE_RELOAD;
                            probe_toggle <= ~probe_toggle;
                            busy         <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end else if (settle_cnt_q != '0) begin
                        settle_cnt_q <= settle_cnt_q - 1'b1;
                    end else if (last_cap) begin
                        state_q      <= DONE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        v_avg        <= st_sum / real'(st_count);
                        v_min        <= st_min;
                        v_max        <= st_max;
                        sample_count <= st_count;
                    end else if (interval_q == '0) begin
                        settle_cnt_q <= SETTLE_RELOAD;
                        probe_toggle <= ~probe_toggle;
                    end else begin
                        state_q    <= WAIT;
                        wait_cnt_q <= interval_q - 1'b1;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end else if (wait_cnt_q == '0) begin
                        state_q      <= SETTLE;
                        settle_cnt_q <= SETTLE_RELOAD;
                        probe_toggle <= ~probe_toggle;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_probe_averager.sv
// Directed bench for probe_averager with a behavioural probe feeding voltage on each toggle.
module tb_probe_averager;

    localparam int MAXS   = 16;
    localparam int SETTLE = 2;
    localparam int CW     = $clog2(MAXS + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] num_samples = '0;
    logic [15:0]   interval = '0;
    real           voltage = 0.0;
    logic          probe_toggle, busy, done;
    real           v_avg, v_min, v_max;
    logic [CW-1:0] sample_count;
    logic [1:0]    state_o;

    int  n_checks = 0;
    int  n_fail = 0;
    real v_seq[$];
    int  tog_cnt = 0;
    int  tog_cyc[$];
    int  cyc = 0;
    logic tog_prev = 1'b0;
    int  dcnt, done_at;

    probe_averager #(
        .MAX_SAMPLES(MAXS),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .num_samples  (num_samples),
        .interval     (interval),
        .voltage      (voltage),
        .probe_toggle (probe_toggle),
        .busy         (busy),
        .done         (done),
        .v_avg        (v_avg),
        .v_min        (v_min),
        .v_max        (v_max),
        .sample_count (sample_count),
        .state_o      (state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // Probe model: every toggle presents the next queued voltage.
    always @(negedge clk) begin
        cyc++;
        if (reset_n && (probe_toggle != tog_prev)) begin
            tog_cnt++;
            tog_cyc.push_back(cyc);
            if (v_seq.size() > 0) voltage = v_seq.pop_front();
        end
        tog_prev = probe_toggle;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input real got, input real exp);
        n_checks++;
        if ((got - exp) > 1e-9 || (exp - got) > 1e-9) begin
            n_fail++;
            $display("FAIL %s: got %0.4f expected %0.4f", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic start_run(input int ns, input int iv);
        @(posedge clk); #1;
        start = 1'b1;
        num_samples = CW'(ns);
        interval = 16'(iv);
        @(posedge clk); #1;
        start = 1'b0;
        tog_cnt = 0;
        tog_cyc.delete();
    endtask

    task automatic do_run(input int ns, input int iv, output int dc, output int d_at);
        bit fin;
        start_run(ns, iv);
        dc = 0;
        d_at = -1;
        fin = 1'b0;
        for (int i = 0; i < 1000 && !fin; i++) begin
            @(negedge clk);
            if (done) begin
                dc++;
                if (d_at < 0) d_at = i + 1;
            end
            if (!busy && !done) fin = 1'b1;
        end
        check_val("run_finished", fin, 1);
    endtask

    task automatic wait_in_wait(input int ntog);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            if (state_o == 2'd2 && tog_cnt >= ntog) hit = 1'b1;
        end
        check_val("reach_wait", hit, 1);
    endtask

    task automatic check_results(input string tag, input real a, input real mn, input real mx, input int n);
        check_val({tag, "_avg"}, v_avg, a);
        check_val({tag, "_min"}, v_min, mn);
        check_val({tag, "_max"}, v_max, mx);
        check_val({tag, "_count"}, sample_count, n);
    endtask

    // ---------------- sequence ----------------
    initial begin
        @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_toggle", probe_toggle, 0);
        check_val("rst_state", state_o, 0);
        check_results("rst", 0.0, 0.0, 0.0, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Constant 0.5 V, 4 samples, interval 3: toggles are SETTLE+3 = 5 cycles apart.
        voltage = 0.5;
        do_run(4, 3, dcnt, done_at);
        check_val("const_toggles", tog_cnt, 4);
        check_val("const_done", dcnt, 1);
        check_val("const_gap", tog_cyc[1] - tog_cyc[0], 5);
        check_results("const", 0.5, 0.5, 0.5, 4);

        // 1.0, 3.0, 2.0 with interval 0: back-to-back settles.
        v_seq.push_back(1.0); v_seq.push_back(3.0); v_seq.push_back(2.0);
        do_run(3, 0, dcnt, done_at);
        check_val("seq_toggles", tog_cnt, 3);
        check_val("seq_done", dcnt, 1);
        check_val("seq_gap0", tog_cyc[1] - tog_cyc[0], SETTLE);
        check_val("seq_gap1", tog_cyc[2] - tog_cyc[1], SETTLE);
        check_results("seq", 2.0, 1.0, 3.0, 3);

        // Mixed sign: -1.5 then 2.5.
        v_seq.push_back(-1.5); v_seq.push_back(2.5);
        do_run(2, 1, dcnt, done_at);
        check_results("neg", 0.5, -1.5, 2.5, 2);

        // Zero samples: immediate done, no toggles, zeroed results.
        do_run(0, 5, dcnt, done_at);
        check_val("zero_done_at", done_at, 1);
        check_val("zero_done", dcnt, 1);
        check_val("zero_toggles", tog_cnt, 0);
        check_results("zero", 0.0, 0.0, 0.0, 0);

        // Over-range request clamps to MAX_SAMPLES.
        voltage = 1.25;
        do_run(31, 0, dcnt, done_at);
        check_val("clamp_toggles", tog_cnt, MAXS);
        check_val("clamp_done", dcnt, 1);
        check_results("clamp", 1.25, 1.25, 1.25, MAXS);

        // Abort in WAIT after the 2nd capture of 5.
        voltage = 7.0;
        start_run(5, 4);
        wait_in_wait(2);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check_val("abort_busy", busy, 0);
        check_val("abort_state", state_o, 0);
        dcnt = done ? 1 : 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        check_val("abort_no_done", dcnt, 0);
        check_results("abort", 1.25, 1.25, 1.25, MAXS);

        // Abort coinciding with the final capture edge of a 1-sample run.
        voltage = 9.0;
        start_run(1, 0);
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check_val("abort_cap_done", done, 0);
        check_val("abort_cap_state", state_o, 0);
        check_results("abort_cap", 1.25, 1.25, 1.25, MAXS);

        // Reset pulse while in WAIT, then a clean run.
        voltage = 3.0;
        start_run(4, 6);
        wait_in_wait(1);
        reset_n = 1'b0;
        #1;
        check_val("mrst_busy", busy, 0);
        check_val("mrst_toggle", probe_toggle, 0);
        check_val("mrst_state", state_o, 0);
        check_results("mrst", 0.0, 0.0, 0.0, 0);
        @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("mrst_idle", state_o, 0);
        v_seq.delete();
        v_seq.push_back(4.0); v_seq.push_back(6.0);
        do_run(2, 1, dcnt, done_at);
        check_val("post_rst_toggles", tog_cnt, 2);
        check_val("post_rst_done", dcnt, 1);
        check_results("post_rst", 5.0, 4.0, 6.0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/probe_averager.md
PROBE_AVERAGER -- requirements
Module: probe_averager

Interface
REQ-001 SHALL have parameter MAX_SAMPLES, default 16, the largest accepted sample count per run.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, the clock cycles between a probe toggle and the voltage capture (minimum 1).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  requests a measurement run; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancels a run in progress.
REQ-007 SHALL have port num_samples  input  $clog2(MAX_SAMPLES+1)  the number of samples for this run.
REQ-008 SHALL have port interval  input  16  the idle cycles between a capture and the next toggle.
REQ-009 SHALL have port voltage  input  real  the analog probe voltage result.
REQ-010 SHALL have port probe_toggle  output  1  inverts once per requested probe.
REQ-011 SHALL have ports busy and done  output  1 each; done is a 1-cycle pulse.
REQ-012 SHALL have ports v_avg, v_min, v_max  output  real  the run statistics.
REQ-013 SHALL have port sample_count  output  $clog2(MAX_SAMPLES+1)  the number of samples captured in the last run.

Function
REQ-014 SHALL use FSM states IDLE, SETTLE, WAIT, DONE.
REQ-015 In IDLE, start=1 with num_samples>0 SHALL latch num_samples (clamped to MAX_SAMPLES) and interval, invert probe_toggle, clear the accumulators, and enter SETTLE.
REQ-016 The FSM SHALL stay in SETTLE for exactly SETTLE_CYCLES cycles, then capture voltage on the edge leaving SETTLE.
REQ-017 Each capture SHALL add voltage to a real sum, update the running min and max, and increment the count; the first capture initialises both min and max.
REQ-018 After a non-final capture, interval>0 SHALL enter WAIT for interval cycles and then re-toggle into SETTLE; interval=0 SHALL toggle on the capture edge and re-enter SETTLE directly.
REQ-019 After the final capture the FSM SHALL enter DONE for one cycle with done=1, and v_avg=sum/count, v_min, v_max and sample_count updated on that same edge; the FSM then returns to IDLE.
REQ-020 In IDLE, start=1 with num_samples=0 SHALL enter DONE without toggling and report v_avg=v_min=v_max=0.0 and sample_count=0.
REQ-021 busy SHALL be 1 in SETTLE and WAIT and 0 otherwise; start while busy SHALL be ignored.
REQ-022 abort=1 in SETTLE or WAIT SHALL return the FSM to IDLE on the next edge with no done pulse and the previous results retained; abort has priority over a simultaneous capture.
REQ-023 Results SHALL hold their values until the next DONE.
REQ-024 The number of probe_toggle inversions per completed run SHALL equal the clamped num_samples.

Reset
REQ-025 reset_n=0 SHALL asynchronously force state IDLE, probe_toggle=0, busy=0, done=0, v_avg=v_min=v_max=0.0, sample_count=0, and clear the accumulators.
REQ-026 Reset asserted mid-run SHALL discard the run; after release the block SHALL wait in IDLE for start.

Structure
REQ-027 The FSM state enum and the default-parameter constants SHALL live in a shared package probe_pkg.
REQ-028 The min/max/sum accumulation SHALL be a sub-module probe_stats (inputs: clear, capture enable, voltage; outputs: sum, min, max, count).
REQ-029 probe_toggle SHALL connect to the probe block's voltage-toggle input, and voltage SHALL come from that block's voltage output.

Verification
REQ-030 Constant voltage 0.5, num_samples=4, interval=3 -> 4 toggles, v_avg=v_min=v_max=0.5, sample_count=4, one done pulse.
REQ-031 Voltage sequence 1.0, 3.0, 2.0, num_samples=3, interval=0 -> v_avg=2.0, v_min=1.0, v_max=3.0, toggles spaced SETTLE_CYCLES cycles apart.
REQ-032 num_samples=0 -> done on the cycle after start, zero toggles, all results 0.0 and sample_count=0.
REQ-033 num_samples=31 with MAX_SAMPLES=16 -> exactly 16 captures and sample_count=16.
REQ-034 abort after the 2nd capture of 5 -> busy=0 on the next cycle, no done pulse, results unchanged from the prior run.
REQ-035 reset_n pulsed low in WAIT -> all outputs reset immediately; a new start then completes normally.
